// File: rtl/tl45_wb_ram.sv
`default_nettype none
// ============================================================================
// Module      : tl45_wb_ram
// Description : Pipelined Wishbone B4 responder. It is a word-addressed
//               on-chip RAM with byte-lane writes, a fixed response latency,
//               an outstanding-request limit, and a bus error for addresses
//               out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module tl45_wb_ram #(
    parameter int ADDR_WIDTH      = 12,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err,
    output logic [31:0] o_wb_data
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [2:0] c_MAX_OUT = 3'(MAX_OUTSTANDING);

    logic [31:0]                 r_mem [0:DEPTH-1];
    logic [2:0]                  r_outstanding;
    logic [LATENCY-1:0]          r_valid;
    logic [LATENCY-1:0]          r_err;
    logic [LATENCY-1:0][31:0]    r_data;

    logic                        w_accept;
    logic                        w_bad;
    logic                        w_resp;
    logic                        w_stall;
    logic [ADDR_WIDTH-1:0]       w_index;

    // An address is bad when any word-address bit above the array is set
    generate
        if (ADDR_WIDTH < 30) begin : g_addr_chk
            assign w_bad = |i_wb_addr[29:ADDR_WIDTH];
        end else begin : g_no_addr_chk
            assign w_bad = 1'b0;
        end
    endgenerate

    assign w_index  = i_wb_addr[ADDR_WIDTH-1:0];
    // The stall comes only from registered state. A response in this cycle
    // lowers the count at the next edge, so the stall drops in the cycle after.
    assign w_stall  = i_wb_cyc && (r_outstanding == c_MAX_OUT);
    assign w_accept = i_wb_cyc && i_wb_stb && !w_stall;
    assign w_resp   = r_valid[LATENCY-1];

    // Byte-lane writes commit at the accept edge, for in-range addresses only
    always_ff @(posedge i_clk) begin
        if (w_accept && i_wb_we && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    r_mem[w_index][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline and outstanding counter. A low cyc aborts every pending response.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid       <= '0;
            r_err         <= '0;
            r_data        <= '0;
            r_outstanding <= '0;
        end else if (!i_wb_cyc) begin
            r_valid       <= '0;
            r_err         <= '0;
            r_data        <= '0;
            r_outstanding <= '0;
        end else begin
            // Stage 0 captures the pre-write word. The data of write, error and
            // empty slots is zero, so the output needs no extra gating.
            r_valid[0] <= w_accept;
            r_err[0]   <= w_accept && w_bad;
            r_data[0]  <= (w_accept && !i_wb_we && !w_bad) ? r_mem[w_index] : 32'h0;
            for (int s = 1; s < LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_err[s]   <= r_err[s-1];
                r_data[s]  <= r_data[s-1];
            end
            r_outstanding <= r_outstanding + {2'b00, w_accept} - {2'b00, w_resp};
        end
    end

    assign o_wb_ack   = r_valid[LATENCY-1] && !r_err[LATENCY-1];
    assign o_wb_err   = r_valid[LATENCY-1] &&  r_err[LATENCY-1];
    assign o_wb_data  = r_data[LATENCY-1];
    assign o_wb_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_tl45_wb_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl45_wb_ram
// Description : Self-checking bench for tl45_wb_ram. It has a LATENCY=1 instance
//               and a LATENCY=3 instance. It checks them against a model of
//               the response queue and the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl45_wb_ram;

    localparam int AW   = 12;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dsel;

    logic        ack1, stall1, err1, ack3, stall3, err3;
    logic [31:0] rd1, rd3;

    always #5 clk = ~clk;

    tl45_wb_ram #(.ADDR_WIDTH(AW), .LATENCY(1), .MAX_OUTSTANDING(MAXO)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc && (dsel == 0)), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_ack(ack1), .o_wb_stall(stall1), .o_wb_err(err1), .o_wb_data(rd1));

    tl45_wb_ram #(.ADDR_WIDTH(AW), .LATENCY(3), .MAX_OUTSTANDING(MAXO)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc && (dsel == 1)), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_ack(ack3), .o_wb_stall(stall3), .o_wb_err(err3), .o_wb_data(rd3));

    // Reference model: the queue of promised responses, each with the edge
    // after which it must be visible, and the memory image of each instance.
    typedef struct {
        int          resp_edge;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       pend[$];
    logic [31:0] mdl_mem [logic [30:0]];
    int          edge_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic        obs_ack, obs_err, obs_stall, exp_ack, exp_err, exp_stall;
    logic [31:0] obs_data, exp_data;
    bit          last_acc;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        logic [30:0] k;
        k = {dsel[0], a};
        return mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
    endfunction

    // Drive one bus cycle, move the model through the edge, then sample the outputs.
    task automatic run_cycle(input bit c, input bit s, input bit w, input logic [29:0] a,
                             input logic [31:0] d, input logic [3:0] bs);
        resp_t       r;
        bit          bad;
        logic [31:0] mask;
        cyc = c; stb = s; we = w; addr = a; wdata = d; sel = bs;
        #1;
        obs_stall = dsel[0] ? stall3 : stall1;
        exp_stall = c && (pend.size() == MAXO);
        last_acc  = c && s && !exp_stall;
        @(posedge clk);
        edge_cnt++;
        if (!c) begin
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].resp_edge == edge_cnt - 1) void'(pend.pop_front());
            if (last_acc) begin
                bad         = (a >> AW) != 0;
                r.err       = bad;
                r.data      = (!w && !bad) ? mem_rd(a) : 32'h0;
                r.resp_edge = edge_cnt + (dsel[0] ? 3 : 1) - 1;
                if (w && !bad) begin
                    mask = {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
                    mdl_mem[{dsel[0], a}] = (mem_rd(a) & ~mask) | (d & mask);
                end
                pend.push_back(r);
            end
        end
        #1;
        obs_ack  = dsel[0] ? ack3 : ack1;
        obs_err  = dsel[0] ? err3 : err1;
        obs_data = dsel[0] ? rd3  : rd1;
        exp_ack  = 1'b0; exp_err = 1'b0; exp_data = 32'h0;
        if (pend.size() > 0 && pend[0].resp_edge == edge_cnt) begin
            exp_ack  = !pend[0].err;
            exp_err  = pend[0].err;
            exp_data = pend[0].data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0; dsel = 0;
        repeat (2) @(posedge clk);
        #2 cyc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dsel = i;
            #1;
            obs_ack  = dsel[0] ? ack3 : ack1;
            obs_err  = dsel[0] ? err3 : err1;
            obs_data = dsel[0] ? rd3  : rd1;
            obs_stall = dsel[0] ? stall3 : stall1;
            checks++;
            if ({obs_ack, obs_err, obs_stall, obs_data} !== 35'h0) begin
                errors++;
                $display("FAIL reset_state inst=%0d: got ack=%b err=%b stall=%b data=%h, want all 0",
                         i, obs_ack, obs_err, obs_stall, obs_data);
            end
        end
        cyc = 1'b0; dsel = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); edge_cnt++;
        #1;
    endtask

    task automatic test_basic();
        dsel = 0;
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 1, 30'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({obs_ack, obs_err, obs_data} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL basic_write: got ack=%b err=%b data=%h, want ack=1 err=0 data=0", obs_ack, obs_err, obs_data);
        end
        run_cycle(1, 1, 0, 30'h10, 0, 4'h0);
        checks++;
        if ({obs_ack, obs_err, obs_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_read: got ack=%b err=%b data=%h, want ack=1 err=0 data=deadbeef", obs_ack, obs_err, obs_data);
        end
        run_cycle(1, 0, 0, 0, 0, 0);
        checks++;
        if ({obs_ack, obs_err} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle: got ack=%b err=%b, want 0 0", obs_ack, obs_err);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] wd [4]  = '{32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h0};
        logic [3:0]  ws [4]  = '{4'hF, 4'h5, 4'h0, 4'h0};
        bit          wr [4]  = '{1, 1, 1, 0};
        dsel = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 1, wr[i], 30'h20, wd[i], ws[i]);
            checks++;
            if ({obs_ack, obs_err, obs_data} !== {exp_ack, exp_err, exp_data}) begin
                errors++;
                $display("FAIL byte_lanes step %0d: got ack=%b err=%b data=%h, want ack=%b err=%b data=%h",
                         i, obs_ack, obs_err, obs_data, exp_ack, exp_err, exp_data);
            end
        end
        checks++;
        if ({obs_ack, obs_data} !== {1'b1, 32'h11BB33DD}) begin
            errors++;
            $display("FAIL byte_lanes_final: got ack=%b data=%h, want ack=1 data=11bb33dd", obs_ack, obs_data);
        end
    endtask

    task automatic test_bad_addr();
        logic [29:0] ad [4] = '{30'hFFF, 30'h1000, 30'h3FFFFFFF, 30'hFFF};
        bit          wr [4] = '{1, 0, 1, 0};
        logic [31:0] dd [4] = '{32'h5A5A5A5A, 32'h0, 32'h12345678, 32'h0};
        dsel = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 1, wr[i], ad[i], dd[i], 4'hF);
            checks++;
            if ({obs_ack, obs_err, obs_data} !== {exp_ack, exp_err, exp_data}) begin
                errors++;
                $display("FAIL bad_addr step %0d: got ack=%b err=%b data=%h, want ack=%b err=%b data=%h",
                         i, obs_ack, obs_err, obs_data, exp_ack, exp_err, exp_data);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if ({obs_ack, obs_err, obs_data} !== {1'b0, 1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL bad_addr_err %0d: got ack=%b err=%b data=%h, want ack=0 err=1 data=0",
                             i, obs_ack, obs_err, obs_data);
                end
            end
        end
        checks++;
        if (obs_data !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL bad_addr_unchanged: got %h, want 5a5a5a5a", obs_data);
        end
    endtask

    task automatic test_stall();
        int idx = 0, n_acc = 0, acks = 0, acc_at_stall = -1;
        dsel = 1;
        run_cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            run_cycle(1, i < 4, 1, 30'(i), $urandom, 4'hF);
            checks++;
            if ({obs_ack, obs_err, obs_data, obs_stall} !== {exp_ack, exp_err, exp_data, exp_stall}) begin
                errors++;
                $display("FAIL stall_prefill %0d: got ack=%b err=%b data=%h stall=%b, want %b %b %h %b",
                         i, obs_ack, obs_err, obs_data, obs_stall, exp_ack, exp_err, exp_data, exp_stall);
            end
        end
        for (int i = 0; i < 16; i++) begin
            run_cycle(1, idx < 4, 0, 30'(idx), 0, 4'hF);
            if (obs_stall && acc_at_stall < 0) acc_at_stall = n_acc;
            if (last_acc) begin idx++; n_acc++; end
            if (obs_ack) acks++;
            checks++;
            if ({obs_ack, obs_err, obs_data, obs_stall} !== {exp_ack, exp_err, exp_data, exp_stall}) begin
                errors++;
                $display("FAIL stall_read %0d: got ack=%b err=%b data=%h stall=%b, want %b %b %h %b",
                         i, obs_ack, obs_err, obs_data, obs_stall, exp_ack, exp_err, exp_data, exp_stall);
            end
        end
        checks++;
        if (acks !== 4 || acc_at_stall !== 2) begin
            errors++;
            $display("FAIL stall_summary: got acks=%0d stall_after=%0d, want acks=4 stall_after=2", acks, acc_at_stall);
        end
    endtask

    task automatic test_abort();
        int acks = 0;
        dsel = 1;
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 0, 30'h0, 0, 4'hF);
        run_cycle(1, 1, 0, 30'h1, 0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0);
            checks++;
            if ({obs_ack, obs_err, obs_data} !== 34'h0) begin
                errors++;
                $display("FAIL abort_quiet %0d: got ack=%b err=%b data=%h, want all 0", i, obs_ack, obs_err, obs_data);
            end
        end
        run_cycle(1, 1, 0, 30'h2, 0, 4'hF);
        checks++;
        if (obs_stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart_stall: got %b, want 0", obs_stall);
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 0, 0, 0, 0, 0);
            if (obs_ack) acks++;
            checks++;
            if ({obs_ack, obs_err, obs_data} !== {exp_ack, exp_err, exp_data}) begin
                errors++;
                $display("FAIL abort_restart %0d: got ack=%b err=%b data=%h, want ack=%b err=%b data=%h",
                         i, obs_ack, obs_err, obs_data, exp_ack, exp_err, exp_data);
            end
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL abort_ack_count: got %0d, want 1", acks);
        end
    endtask

    task automatic test_async_reset();
        dsel = 1;
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 1, 30'h40, 32'hCAFEF00D, 4'hF);
        repeat (3) run_cycle(1, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 0, 30'h40, 0, 4'hF);
        run_cycle(1, 1, 0, 30'h20000000, 0, 4'hF);
        run_cycle(1, 0, 0, 0, 0, 0);
        checks++;
        if ({obs_ack, obs_data} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL reset_pre_ack: got ack=%b data=%h, want ack=1 data=cafef00d", obs_ack, obs_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ack3, err3, rd3} !== 34'h0) begin
            errors++;
            $display("FAIL reset_async: got ack=%b err=%b data=%h, want all 0", ack3, err3, rd3);
        end
        @(posedge clk); edge_cnt++; pend.delete();
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 0, 0, 0, 0, 0);
            checks++;
            if ({obs_ack, obs_err, obs_stall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_drop %0d: got ack=%b err=%b stall=%b, want 0 0 0", i, obs_ack, obs_err, obs_stall);
            end
        end
        run_cycle(1, 1, 0, 30'h40, 0, 4'hF);
        repeat (2) run_cycle(1, 0, 0, 0, 0, 0);
        checks++;
        if ({obs_ack, obs_data} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL reset_mem_kept: got ack=%b data=%h, want ack=1 data=cafef00d", obs_ack, obs_data);
        end
    endtask

    task automatic test_random();
        logic [29:0] a;
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            run_cycle(0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 8; i++) run_cycle(1, 1, 1, 30'h100 + 30'(i), $urandom, 4'hF);
            for (int i = 0; i < 300; i++) begin
                a = ($urandom_range(0, 9) == 0) ? (30'($urandom) | 30'h1000)
                                                : 30'h100 + 30'($urandom_range(0, 7));
                run_cycle($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                          a, $urandom, 4'($urandom_range(0, 15)));
                checks++;
                if ({obs_ack, obs_err, obs_data, obs_stall} !== {exp_ack, exp_err, exp_data, exp_stall}) begin
                    errors++;
                    $display("FAIL random inst=%0d cyc=%0d: got ack=%b err=%b data=%h stall=%b, want %b %b %h %b",
                             d, i, obs_ack, obs_err, obs_data, obs_stall, exp_ack, exp_err, exp_data, exp_stall);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_bad_addr();
        test_stall();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tl45_wb_ram.md
Name: tl45_wb_ram

Overview:
- Pipelined Wishbone B4 responder: word-addressed on-chip RAM with byte-lane writes.
- Serves the core's memory stage (the Wishbone initiator) as its data store on the shared bus.
- Responses return with a fixed, parameterised latency.
- Accepted requests are throttled by an outstanding-transaction limit.
- Out-of-range addresses get a bus error.

Parameters:
- ADDR_WIDTH, 12, number of word-address bits implemented; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from the request-accept edge to the ack/err cycle; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..4.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  30  word address.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte enables; sel[3] maps to data[31:24] ... sel[0] maps to data[7:0].
- o_wb_ack  out  1  successful response, one cycle per accepted good request.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_err  out  1  error response, one cycle per accepted bad request.
- o_wb_data  out  32  read data; valid only while o_wb_ack is high.

Behaviour:
- Accept condition: i_wb_cyc && i_wb_stb && !o_wb_stall at the rising edge. At most one accept per cycle.
- Stall rule: o_wb_stall = i_wb_cyc && (outstanding == MAX_OUTSTANDING). This is combinational from registered state. A response in the same cycle does not release the stall; the stall drops in the following cycle.
- Outstanding counter: +1 on accept, -1 on each ack/err, net 0 when both happen in the same cycle. Never exceeds MAX_OUTSTANDING.
- Address check: the request is bad when i_wb_addr[29:ADDR_WIDTH] != 0.
  - Bad requests never touch the array.
  - They respond with o_wb_err=1, o_wb_ack=0, o_wb_data=0.
- Writes:
  - The array is updated at the accept edge, good addresses only, per enabled byte lane.
  - sel=0 still acks with no change.
  - A write ack drives o_wb_data=0.
- Reads:
  - The full word is read at the accept edge, independent of sel.
  - A read accepted at the same edge as a write to the same address returns pre-write data; no two accepts can share one edge.
  - A read accepted after a write returns the written data.
- Response pipeline:
  - LATENCY-stage shift register holding {valid, is_err, is_read, data}.
  - A request accepted at edge N produces ack/err high for exactly the cycle following edge N+LATENCY-1. For LATENCY=1 that is the cycle immediately after the accept edge.
  - Responses come out in acceptance order. Back-to-back accepts give back-to-back responses.
- Abort: while i_wb_cyc=0 at an edge:
  - Clear all pipeline valid bits and the counter.
  - Force ack/err/data to 0 at that edge.
  - Writes already accepted stay committed.
  - No ack/err is ever driven in a cycle after an edge at which cyc was low, until new accepts occur.
- Reset (asynchronous, active-high):
  - o_wb_ack=0, o_wb_err=0, o_wb_data=0, counter=0, all pipeline valid bits cleared.
  - o_wb_stall follows its equation and is therefore 0.
  - Array contents are not cleared by reset; they power up to 0 for simulation.
  - Reset mid-transaction drops all pending responses.
- Unused: the stb-without-cyc case is ignored.

Test Plan:
- LATENCY=1: write addr 0x10, data 0xDEADBEEF, sel 0xF, then read 0x10 -> write acks with data 0; read acks one cycle after its accept with o_wb_data=0xDEADBEEF.
- Byte lanes: word 0x20 = 0x11223344, then write data 0xAABBCCDD with sel=0x5, then read -> 0x11BB33DD. sel=0 write -> ack, word unchanged.
- LATENCY=3, MAX_OUTSTANDING=2: stb held high for 4 consecutive reads of 0..3 -> stall asserts after 2 accepts. Acks arrive in order with correct data and the counter never exceeds 2. Total 4 acks, no more.
- Bad address: read of 0x0000_1000 with ADDR_WIDTH=12 -> o_wb_err pulses once, no ack, o_wb_data=0. A write to 0x3FFF_FFFF -> err, and array word 0xFFF is unchanged.
- Abort: LATENCY=3, accept 2 reads, drop cyc the next cycle -> no ack/err ever appears and the counter is 0. A new cycle accepts immediately with stall=0.
- Async reset asserted between clock edges with 2 requests in flight -> ack/err/data go to 0 immediately, no pending responses after release, and memory written earlier still reads back correctly.
